// File: rtl/am_tx_sample_scheduler.sv
// am_tx_sample_scheduler
//
// Sequences the AM transmitter datapath. Audio bytes from the upstream
// source are buffered in a small FIFO. Once the FIFO holds enough bytes the
// scheduler releases one byte per sample period to the modulator. It also
// owns the carrier NCO phase increment and applies retunes only on sample
// boundaries, so a frequency change never lands in the middle of a sample.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   enable         transmit enable; low forces IDLE (FIFO contents are kept)
//   in_data        unsigned audio byte from upstream
//   in_valid       in_data valid
//   in_ready       FIFO not full (combinational)
//   cfg_freq_word  new carrier phase increment
//   cfg_freq_we    one-cycle write strobe for cfg_freq_word
//   signal         registered byte to the modulator
//   sample_strobe  one-cycle pulse when signal takes a new sample
//   phase_inc      registered NCO phase increment
//   state          0=IDLE 1=PRIME 2=RUN
//   fifo_level     current FIFO occupancy
//   underrun_cnt   saturating count of sample periods with an empty FIFO
module am_tx_sample_scheduler #(
   parameter int          SAMPLE_DIV  = 2000,
   parameter int          FIFO_AW     = 4,
   parameter int          PRIME_LEVEL = 8,
   parameter logic [31:0] DEFAULT_INC = 32'h0A3D70A4,
   parameter logic [7:0]  SILENCE     = 8'h80
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        cfg_freq_word,
   input  logic               cfg_freq_we,
   output logic [7:0]         signal,
   output logic               sample_strobe,
   output logic [31:0]        phase_inc,
   output logic [1:0]         state,
   output logic [FIFO_AW:0]   fifo_level,
   output logic [15:0]        underrun_cnt
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int DIV_W = $clog2(SAMPLE_DIV);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [FIFO_AW:0] PRIME_LVL = (FIFO_AW + 1)'(PRIME_LEVEL);
   localparam logic [FIFO_AW:0] FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t               fsm_state;
   logic [DIV_W-1:0]     divider;
   logic [DIV_W-1:0]     div_next;
   logic                 tick;

   logic [7:0]           fifo_mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr;
   logic [FIFO_AW-1:0]   rd_ptr;
   logic                 push;
   logic                 pop;

   logic                 pending;
   logic [31:0]          pending_word;

   // Handshake and sample-boundary decode. The divider is held at zero in
   // IDLE, so tick can only fire in PRIME or RUN. A pop uses the registered
   // occupancy, which is what keeps a byte pushed this cycle out of reach
   // until the next one.
   always_comb begin
      in_ready = (fifo_level != FULL_LVL);
      push     = in_valid && in_ready;
      tick     = (fsm_state != S_IDLE) && (divider == DIV_LAST);
      div_next = tick ? '0 : divider + 1'b1;
      pop      = enable && (fsm_state == S_RUN) && tick && (fifo_level != '0);
      state    = fsm_state;
   end

   // FIFO storage. The data array needs no reset; validity is tracked by the
   // pointers and the occupancy counter.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= in_data;
      end
   end

   // FIFO pointers and occupancy. A simultaneous push and pop leaves the
   // level unchanged. Reset throws away anything buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Transmit sequencer. Dropping enable wins over everything and parks the
   // output at midscale. In RUN every tick produces a strobe: either the next
   // buffered byte or, when the FIFO has run dry, silence plus an underrun
   // count and a return to PRIME so the buffer can refill before resuming.
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_state     <= S_IDLE;
         divider       <= '0;
         signal        <= SILENCE;
         sample_strobe <= 1'b0;
         underrun_cnt  <= '0;
      end else if (!enable) begin
         fsm_state     <= S_IDLE;
         divider       <= '0;
         signal        <= SILENCE;
         sample_strobe <= 1'b0;
      end else begin
         sample_strobe <= 1'b0;
         case (fsm_state)
            S_IDLE: begin
               fsm_state <= S_PRIME;
               divider   <= '0;
            end
            S_PRIME: begin
               divider <= div_next;
               if (fifo_level >= PRIME_LVL) begin
                  fsm_state <= S_RUN;
               end
            end
            S_RUN: begin
               divider <= div_next;
               if (tick) begin
                  sample_strobe <= 1'b1;
                  if (fifo_level != '0) begin
                     signal <= fifo_mem[rd_ptr];
                  end else begin
                     signal    <= SILENCE;
                     fsm_state <= S_PRIME;
                     if (underrun_cnt != 16'hFFFF) begin
                        underrun_cnt <= underrun_cnt + 16'd1;
                     end
                  end
               end
            end
            default: begin
               fsm_state <= S_IDLE;
               divider   <= '0;
            end
         endcase
      end
   end

   // Carrier retune. Writes land in a pending register (last write wins) and
   // are moved into phase_inc on the next sample boundary. A write in the
   // same cycle as a tick bypasses the pending register so it takes effect
   // at that boundary. With no sample clock running (IDLE) a pending word is
   // applied on the following cycle instead of waiting for a tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_inc    <= DEFAULT_INC;
         pending      <= 1'b0;
         pending_word <= '0;
      end else if (tick && (cfg_freq_we || pending)) begin
         phase_inc <= cfg_freq_we ? cfg_freq_word : pending_word;
         pending   <= 1'b0;
      end else begin
         if ((fsm_state == S_IDLE) && pending) begin
            phase_inc <= pending_word;
            pending   <= 1'b0;
         end
         if (cfg_freq_we) begin
            pending_word <= cfg_freq_word;
            pending      <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_am_tx_sample_scheduler.sv
// tb_am_tx_sample_scheduler
//
// Self-checking bench for am_tx_sample_scheduler with a short sample period
// (SAMPLE_DIV=4) and a 16-deep FIFO primed at 2 bytes. A reference model
// built from queues and integers predicts every output; released samples go
// through a scoreboard queue that a separate monitor drains on each strobe.
module tb_am_tx_sample_scheduler;

   localparam int          SD      = 4;
   localparam int          AW      = 4;
   localparam int          PL      = 2;
   localparam int          DEPTH   = 16;
   localparam logic [31:0] DEF_INC = 32'h0A3D70A4;
   localparam logic [7:0]  SIL     = 8'h80;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] cfg_freq_word;
   logic        cfg_freq_we;
   logic [7:0]  signal;
   logic        sample_strobe;
   logic [31:0] phase_inc;
   logic [1:0]  state;
   logic [AW:0] fifo_level;
   logic [15:0] underrun_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   am_tx_sample_scheduler #(
      .SAMPLE_DIV  (SD),
      .FIFO_AW     (AW),
      .PRIME_LEVEL (PL),
      .DEFAULT_INC (DEF_INC),
      .SILENCE     (SIL)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .cfg_freq_word (cfg_freq_word),
      .cfg_freq_we   (cfg_freq_we),
      .signal        (signal),
      .sample_strobe (sample_strobe),
      .phase_inc     (phase_inc),
      .state         (state),
      .fifo_level    (fifo_level),
      .underrun_cnt  (underrun_cnt)
   );

   // Reference model state: buffered bytes, mode, position in the sample
   // period, and the carrier configuration.
   logic [7:0]  m_fifo [$];
   logic [7:0]  exp_q  [$];
   int          m_state;
   int          m_div;
   int          m_under;
   int          m_lvl;
   bit          m_tick;
   logic [7:0]  m_sig;
   logic        m_strobe;
   logic [31:0] m_inc;
   logic [31:0] m_pend_word;
   bit          m_pend;
   bit          mon_en = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit en, input bit vld,
                                input logic [7:0] d, input bit we,
                                input logic [31:0] w);
      reset         = rst;
      enable        = en;
      in_valid      = vld;
      in_data       = d;
      cfg_freq_we   = we;
      cfg_freq_word = w;
      @(posedge clk);
      #2;
   endtask

   // Model update on every rising edge using the inputs presented in the
   // cycle that just ended. Any released sample is queued for the monitor.
   always @(posedge clk) begin
      if (reset) begin
         m_fifo.delete();
         m_state  = 0;
         m_div    = 0;
         m_under  = 0;
         m_sig    = SIL;
         m_strobe = 1'b0;
         m_inc    = DEF_INC;
         m_pend   = 0;
      end else begin
         m_lvl  = m_fifo.size();
         m_tick = (m_state != 0) && (m_div == SD - 1);

         if (m_tick && (cfg_freq_we || m_pend)) begin
            m_inc  = cfg_freq_we ? cfg_freq_word : m_pend_word;
            m_pend = 0;
         end else begin
            if (m_state == 0 && m_pend) begin
               m_inc  = m_pend_word;
               m_pend = 0;
            end
            if (cfg_freq_we) begin
               m_pend_word = cfg_freq_word;
               m_pend      = 1;
            end
         end

         m_strobe = 1'b0;
         if (!enable) begin
            m_state = 0;
            m_div   = 0;
            m_sig   = SIL;
         end else if (m_state == 0) begin
            m_state = 1;
         end else begin
            m_div = m_tick ? 0 : m_div + 1;
            if (m_state == 1) begin
               if (m_lvl >= PL) m_state = 2;
            end else if (m_tick) begin
               m_strobe = 1'b1;
               if (m_lvl > 0) begin
                  m_sig = m_fifo.pop_front();
               end else begin
                  m_sig = SIL;
                  if (m_under < 65535) m_under++;
                  m_state = 1;
               end
               exp_q.push_back(m_sig);
            end
         end

         if (in_valid && (m_lvl < DEPTH)) begin
            m_fifo.push_back(in_data);
         end
      end
      mon_en = 1;
   end

   // Monitor on the falling edge: compares the visible registers against the
   // model every cycle and retires one scoreboard entry per DUT strobe.
   always @(negedge clk) begin
      if (mon_en) begin
         checkOutput("state", 32'(state), 32'(m_state));
         checkOutput("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
         checkOutput("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
         checkOutput("phase_inc", phase_inc, m_inc);
         checkOutput("underrun_cnt", 32'(underrun_cnt), 32'(m_under));
         checkOutput("sample_strobe", 32'(sample_strobe), 32'(m_strobe));
         checkOutput("signal", 32'(signal), 32'(m_sig));
         if (sample_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_strobe actual=%0h expected=none at %0t",
                        signal, $time);
            end else begin
               checkOutput("sample_value", 32'(signal), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      int p_valid;
      logic [7:0] pct [4];

      // Reset, then enabled with nothing to send: sits in PRIME.
      applyStimulus(1, 0, 0, 8'h00, 0, 32'h0);
      applyStimulus(1, 0, 0, 8'h00, 0, 32'h0);
      for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);

      // Three bytes, run until the FIFO underruns back into PRIME.
      applyStimulus(0, 1, 1, 8'h10, 0, 32'h0);
      applyStimulus(0, 1, 1, 8'h20, 0, 32'h0);
      applyStimulus(0, 1, 1, 8'h30, 0, 32'h0);
      for (int i = 0; i < 25; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);

      // Fill past full while disabled, then hold the 17th byte into RUN.
      for (int i = 0; i < 17; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i), 0, 32'h0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 8'h50, 0, 32'h0);
      for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);

      // Back-to-back retunes while running; last one should win.
      applyStimulus(0, 1, 0, 8'h00, 1, 32'h11111111);
      applyStimulus(0, 1, 0, 8'h00, 1, 32'h22222222);
      for (int i = 0; i < 60; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);

      // Drop enable with bytes buffered, then resume without re-pushing.
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 1, 8'(8'hA0 + i), 0, 32'h0);
      applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 8'h00, 0, 32'h0);
      for (int i = 0; i < 30; i++) applyStimulus(0, 1, 0, 8'h00, 0, 32'h0);

      // Retune while idle, then reset in the middle of RUN.
      applyStimulus(0, 0, 0, 8'h00, 1, 32'h33333333);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 0, 32'h0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 8'(8'hC0 + i), 0, 32'h0);
      applyStimulus(0, 1, 0, 8'h00, 1, 32'h44444444);
      applyStimulus(1, 1, 0, 8'h00, 0, 32'h0);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 8'h00, 0, 32'h0);

      // Randomised traffic in segments with different arrival rates so the
      // FIFO sees both starvation and back-pressure.
      pct[0] = 8'd10;
      pct[1] = 8'd25;
      pct[2] = 8'd40;
      pct[3] = 8'd90;
      for (int seg = 0; seg < 40; seg++) begin
         p_valid = int'(pct[$urandom_range(0, 3)]);
         for (int i = 0; i < 100; i++) begin
            applyStimulus($urandom_range(0, 999) < 2,
                          $urandom_range(0, 99) < 97,
                          $urandom_range(0, 99) < p_valid,
                          8'($urandom),
                          $urandom_range(0, 99) < 6,
                          $urandom);
         end
      end

      applyStimulus(0, 0, 0, 8'h00, 0, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
